// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, programmable almost flags, optional
// first-word-fall-through read port, occupancy output and sticky error flags.
module sync_fifo_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    if (DEPTH < 2 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_cfg
        $error("sync_fifo_ext: need DEPTH>=2 and 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  flush;
    logic                  wr_ok;
    logic                  rd_ok;

    // Explicit wrap so non-power-of-2 depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign flush        = reset | clear;
    assign full         = (cnt == CNT_W'(DEPTH));
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= CNT_W'(AF_THRESH));
    assign almost_empty = (cnt <= CNT_W'(AE_THRESH));
    assign count        = cnt;
    assign wr_ok        = wr_en & ~full;
    assign rd_ok        = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_next(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !flush) mem[wr_ptr] <= din;
    end

    if (FWFT) begin : g_fwft
        assign dout  = mem[rd_ptr];
        assign valid = ~empty;
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (flush) begin
                dout  <= '0;
                valid <= 1'b0;
            end else begin
                valid <= rd_ok;
                if (rd_ok) dout <= mem[rd_ptr];
            end
        end
    end

endmodule
